blinky_mode_ctrl: RTL and testbench
===================================

Name: blinky_mode_ctrl

Overview:
Front-end controller for the board's single-LED blinker. It synchronises and debounces the push button, and each clean press advances a four-state mode sequencer. It drives led0_b with the pattern for the current mode (off, slow blink, fast blink, solid). It sits between the board pins (btn, led0_b) and exposes mode and press status for optional PS/debug readback.

Parameters:
DEBOUNCE_CYCLES, 625000, consecutive stable cycles required to accept a button level change (10 ms at 62.5 MHz); must be >= 1
SLOW_HALF, 31250000, clk cycles per half-period in SLOW mode (0.5 s); must be >= 2
FAST_HALF, 7812500, clk cycles per half-period in FAST mode (0.125 s); must be >= 2

Ports:
clk  input  1  system clock, 62.5 MHz (16 ns period)
rst  input  1  synchronous, active-high reset
btn  input  1  raw asynchronous push-button level, 1 = pressed
led0_b  output  1  LED drive, 1 = on
mode  output  2  current mode: 0 OFF, 1 SLOW, 2 FAST, 3 SOLID
press_pulse  output  1  one-cycle pulse on each accepted press

Behaviour:
- Single clock domain, all state on rising clk. Reset is synchronous, active-high, and has priority over every other event.
- Reset values: led0_b=0, mode=OFF, press_pulse=0. Synchroniser flops, debounced level, its delayed copy, debounce counter and blink counter are all 0.
- Synchroniser: two flops. sync_q1<=btn, sync_q2<=sync_q1. No other logic reads btn.
- Debounce:
  - While sync_q2 != btn_db, dcnt increments each cycle.
  - When dcnt==DEBOUNCE_CYCLES-1 and the levels still differ, btn_db<=sync_q2 and dcnt<=0.
  - Any cycle with sync_q2==btn_db clears dcnt. A glitch shorter than DEBOUNCE_CYCLES is therefore discarded completely.
- Press detect: btn_db_d<=btn_db. The press condition is btn_db & ~btn_db_d.
  - On that condition, press_pulse<=1 for exactly one cycle and mode advances at the same edge.
  - A release (falling btn_db) produces no pulse and no mode change.
- Latency: if btn is first sampled high at edge k and held, btn_db rises at edge k+DEBOUNCE_CYCLES+1. press_pulse and the mode change both occur at edge k+DEBOUNCE_CYCLES+2.
- Mode FSM: OFF -> SLOW -> FAST -> SOLID -> OFF, one step per press. Holding the button never auto-repeats.
- LED generation:
  - OFF: led0_b=0, bcnt held at 0.
  - SOLID: led0_b=1, bcnt held at 0.
  - On entry to SLOW or FAST, at the same edge as the mode change: bcnt<=0 and led0_b<=1.
  - In SLOW/FAST, with HALF = SLOW_HALF or FAST_HALF: bcnt increments each cycle. When bcnt==HALF-1, bcnt<=0 and led0_b toggles.
  - Result: exactly HALF cycles high and HALF cycles low, first phase high.
- Widths: bcnt is $clog2(max(SLOW_HALF,FAST_HALF)) bits; dcnt is $clog2(DEBOUNCE_CYCLES+1) bits. Both wrap only through the explicit compare, never by overflow.
- Reset mid-blink or mid-debounce: everything returns to reset values at that edge. A button still held after reset is released must be accepted as a new press once DEBOUNCE_CYCLES elapse, because btn_db was cleared to 0.

Decomposition:
- Shared package blinky_pkg holds:
  - mode encodings MODE_OFF, MODE_SLOW, MODE_FAST, MODE_SOLID (2-bit localparams);
  - default timing constants CLK_HZ=62500000, DEBOUNCE_10MS, SLOW_HALF_DEF, FAST_HALF_DEF.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn, btn_db, press_pulse) contains the synchroniser, debounce counter and rise detector. It is reusable for further board buttons.
- The mode FSM and blink counter remain in blinky_mode_ctrl.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, SLOW_HALF=8, FAST_HALF=3, clk toggling every 8 ns.)
1. rst=1 for 3 cycles with btn=1, then release rst -> led0_b=0, mode=0, press_pulse=0 during reset; btn still high after reset -> one press accepted, mode=1.
2. btn 0->1 sampled at edge k, held 2000 ns -> press_pulse high only during cycle after edge k+6, mode=1. led0_b then shows 8 cycles high, 8 low, repeating. The 2000 ns release produces no pulse.
3. Glitches on btn of 1, 2 and 3 cycles separated by 5 low cycles -> no press_pulse, mode unchanged, dcnt returns to 0.
4. Four clean presses (2000 ns high / 2000 ns low each) -> mode sequence 1, 2, 3, 0. In FAST mode led0_b shows 3 high / 3 low. In SOLID mode led0_b=1 constantly. In OFF mode led0_b=0.
5. Press arriving mid-phase in SLOW mode (bcnt=5, led0_b=0) -> at the mode edge bcnt=0, led0_b=1, FAST pattern starts immediately.
6. rst asserted for one cycle during FAST blink with btn held -> all outputs back to reset values at that edge. The held button then produces exactly one press, and mode goes to 1.

Source files
------------

// File: rtl/blinky_pkg.sv
// Shared mode encodings and default timing constants for the LED blinker front end.
package blinky_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SLOW  = 2'd1,
    MODE_FAST  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  localparam int unsigned CLK_HZ        = 62500000;
  localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int unsigned SLOW_HALF_DEF = CLK_HZ / 2;
  localparam int unsigned FAST_HALF_DEF = CLK_HZ / 8;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:   next_mode = MODE_SLOW;
      MODE_SLOW:  next_mode = MODE_FAST;
      MODE_FAST:  next_mode = MODE_SOLID;
      default:    next_mode = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level debouncer and rising-edge press detector.
// press_pulse is combinational from registers so the parent can act on the same edge it registers it.
module btn_debounce
  import blinky_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db,
  output logic press_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync_q1;
  logic          r_sync_q2;
  logic          r_btn_db;
  logic          r_btn_db_d;
  logic [DW-1:0] r_dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_q1  <= 1'b0;
      r_sync_q2  <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_dcnt     <= '0;
    end else begin
      r_sync_q1  <= btn;
      r_sync_q2  <= r_sync_q1;
      r_btn_db_d <= r_btn_db;
      // Any cycle agreeing with the accepted level discards the partial count.
      if (r_sync_q2 != r_btn_db) begin
        if (r_dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_btn_db <= r_sync_q2;
          r_dcnt   <= '0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  assign btn_db      = r_btn_db;
  assign press_pulse = r_btn_db & ~r_btn_db_d;

endmodule

// File: rtl/blinky_mode_ctrl.sv
// Button-driven four-mode LED controller: OFF -> SLOW blink -> FAST blink -> SOLID -> OFF.
module blinky_mode_ctrl
  import blinky_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned SLOW_HALF       = SLOW_HALF_DEF,
  parameter int unsigned FAST_HALF       = FAST_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       led0_b,
  output logic [1:0] mode,
  output logic       press_pulse
);

  localparam int unsigned HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int unsigned BW       = $clog2(HALF_MAX);

  logic          w_btn_db;
  logic          w_press;
  logic [BW-1:0] w_half_m1;
  mode_t         w_next_mode;

  mode_t         r_mode;
  logic          r_led;
  logic          r_press;
  logic [BW-1:0] r_bcnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .btn_db     (w_btn_db),
    .press_pulse(w_press)
  );

  always_comb begin
    w_half_m1   = (r_mode == MODE_FAST) ? BW'(FAST_HALF - 1) : BW'(SLOW_HALF - 1);
    w_next_mode = next_mode(r_mode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= MODE_OFF;
      r_led   <= 1'b0;
      r_press <= 1'b0;
      r_bcnt  <= '0;
    end else begin
      r_press <= w_press;
      if (w_press) begin
        // Every mode except OFF starts with the LED on and a fresh half-period.
        r_mode <= w_next_mode;
        r_bcnt <= '0;
        r_led  <= (w_next_mode != MODE_OFF);
      end else begin
        case (r_mode)
          MODE_OFF: begin
            r_led  <= 1'b0;
            r_bcnt <= '0;
          end
          MODE_SOLID: begin
            r_led  <= 1'b1;
            r_bcnt <= '0;
          end
          default: begin
            if (r_bcnt == w_half_m1) begin
              r_bcnt <= '0;
              r_led  <= ~r_led;
            end else begin
              r_bcnt <= r_bcnt + BW'(1);
            end
          end
        endcase
      end
    end
  end

  assign led0_b      = r_led;
  assign mode        = r_mode;
  assign press_pulse = r_press;

endmodule

// File: tb/tb_blinky_mode_ctrl.sv
// Directed bench for blinky_mode_ctrl with short debounce and blink periods.
module tb_blinky_mode_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned SH = 8;
  localparam int unsigned FH = 3;
  localparam int          HOLD = 125;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       led0_b;
  logic [1:0] mode;
  logic       press_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int tb_mode;
  int tb_n;

  always #8 clk = ~clk;

  blinky_mode_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .SLOW_HALF      (SH),
    .FAST_HALF      (FH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .led0_b     (led0_b),
    .mode       (mode),
    .press_pulse(press_pulse)
  );

  typedef struct {
    logic       rst;
    logic       btn;
    logic       led;
    logic [1:0] mode;
    logic       pulse;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_led();
    case (tb_mode)
      0:       exp_led = 1'b0;
      3:       exp_led = 1'b1;
      1:       exp_led = ((tb_n / SH) % 2) == 0;
      default: exp_led = ((tb_n / FH) % 2) == 0;
    endcase
  endfunction

  task automatic run(input int ncyc, input logic b, input int press_at);
    for (int c = 1; c <= ncyc; c++) begin
      btn = b;
      @(posedge clk);
      #1;
      if (c == press_at) begin
        tb_mode = (tb_mode + 1) % 4;
        tb_n    = 0;
      end else begin
        tb_n++;
      end
      chk("led", led0_b, exp_led());
      chk("mode", mode, tb_mode);
      chk("pulse", press_pulse, (c == press_at));
    end
  endtask

  initial begin
    int wait_n;
    rst = 1'b1;
    btn = 1'b1;

    for (int i = 0; i < 3; i++)   vecs[i] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    for (int i = 3; i < 9; i++)   vecs[i] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    for (int i = 10; i < 17; i++) vecs[i] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0};

    // Reset with button held, then debounce latency and first SLOW high phase
    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst;
      btn = vecs[i].btn;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_led", i), led0_b, vecs[i].led);
      chk($sformatf("vec%0d_mode", i), mode, vecs[i].mode);
      chk($sformatf("vec%0d_pulse", i), press_pulse, vecs[i].pulse);
    end
    tb_mode = 1;
    tb_n    = 8;

    // Release: no pulse, SLOW blink continues
    run(24, 1'b0, 0);

    // Glitches of 1, 2 and 3 cycles are discarded
    run(1, 1'b1, 0);
    run(5, 1'b0, 0);
    run(2, 1'b1, 0);
    run(5, 1'b0, 0);
    run(3, 1'b1, 0);
    run(5, 1'b0, 0);
    chk("dcnt_idle", dut.u_db.r_dcnt, 0);

    // Press landing mid low phase of SLOW with bcnt at 5
    wait_n = (7 - (tb_n % 16) + 16) % 16;
    if (wait_n > 0) run(wait_n, 1'b0, 0);
    run(6, 1'b1, 0);
    chk("bcnt_before", dut.r_bcnt, 5);
    run(1, 1'b1, 1);
    chk("bcnt_entry", dut.r_bcnt, 0);
    run(HOLD - 7, 1'b1, 0);
    run(HOLD, 1'b0, 0);

    // FAST -> SOLID -> OFF -> SLOW -> FAST
    run(HOLD, 1'b1, 7);
    run(HOLD, 1'b0, 0);
    run(HOLD, 1'b1, 7);
    run(HOLD, 1'b0, 0);
    run(HOLD, 1'b1, 7);
    run(HOLD, 1'b0, 0);
    run(30, 1'b1, 7);

    // One-cycle reset during FAST blink with the button still held
    rst = 1'b1;
    btn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_led", led0_b, 0);
    chk("rst_mode", mode, 0);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_bcnt", dut.r_bcnt, 0);
    rst     = 1'b0;
    tb_mode = 0;
    tb_n    = 0;
    run(7, 1'b1, 7);
    run(40, 1'b1, 0);
    run(20, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
